// File: rtl/keypad_if.sv
// Command channel of the keypad emulator: one key press request per valid/ready transfer.
interface keypad_if;
  // Transfer happens on the rising clk edge where cmd_valid && cmd_ready; key/hold must be stable then.
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_key;
  logic [15:0] cmd_hold;

  modport master (output cmd_valid, output cmd_key, output cmd_hold, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_key, input cmd_hold, output cmd_ready);
endinterface

// File: rtl/keypad_emulator.sv
// Passive 4x3 matrix keypad: presses a commanded key with LFSR contact bounce, a stable hold and a
// release gap, and answers the scanner's row lines on the column lines one cycle later.
module keypad_emulator #(
    parameter logic [15:0] BOUNCE_CYC = 16'd200,
    parameter logic [15:0] GAP_CYC    = 16'd500,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic           clk,
    input  logic           rst_n,
    keypad_if.slave        cmd,
    input  logic [3:0]     filas,
    output logic [2:0]     columnas,
    output logic           busy,
    output logic           contact,
    output logic           cmd_err,
    output logic [7:0]     press_cnt,
    output logic [2:0]     state_dbg
);
    typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] hold_q, hold_d;
    logic [1:0]  row_q, row_d;
    logic [1:0]  col_q, col_d;
    logic        contact_q, contact_d;
    logic        err_q, err_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic [2:0]  columnas_q, columnas_d;

    always_comb begin
        logic [15:0] lfsr_nx, hold_src, hold_eff, gap_eff;
        logic [3:0]  key_div, key_mod;
        logic        enter;
        state_e      tgt;

        state_d    = state_q;
        cnt_d      = cnt_q;
        lfsr_d     = lfsr_q;
        hold_d     = hold_q;
        row_d      = row_q;
        col_d      = col_q;
        contact_d  = contact_q;
        err_d      = 1'b0;
        pcnt_d     = pcnt_q;
        enter      = 1'b0;
        tgt        = state_q;
        // Fibonacci taps 16,14,13,11 in right-shift form; bit 0 is the bounce sample.
        lfsr_nx    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        key_div    = cmd.cmd_key / 4'd3;
        key_mod    = cmd.cmd_key % 4'd3;
        // In IDLE the hold value is still on the bus; later phases use the latched copy.
        hold_src   = (state_q == IDLE) ? cmd.cmd_hold : hold_q;
        hold_eff   = (hold_src == 16'd0) ? 16'd1 : hold_src;
        gap_eff    = (GAP_CYC == 16'd0) ? 16'd1 : GAP_CYC;

        case (state_q)
            IDLE: begin
                contact_d = 1'b0;
                if (cmd.cmd_valid && ready_q) begin
                    hold_d = cmd.cmd_hold;
                    row_d  = key_div[1:0];
                    col_d  = key_mod[1:0];
                    enter  = 1'b1;
                    if (cmd.cmd_key >= 4'd12) begin
                        err_d = 1'b1;
                        tgt   = GAP;
                    end else begin
                        tgt = (BOUNCE_CYC != 16'd0) ? BOUNCE_IN : HOLD;
                    end
                end
            end
            BOUNCE_IN, BOUNCE_OUT: begin
                if (cnt_q <= 16'd1) begin
                    enter = 1'b1;
                    tgt   = (state_q == BOUNCE_IN) ? HOLD : GAP;
                end else begin
                    cnt_d     = cnt_q - 16'd1;
                    contact_d = lfsr_q[0];
                    lfsr_d    = lfsr_nx;
                end
            end
            HOLD: begin
                if (cnt_q <= 16'd1) begin
                    enter = 1'b1;
                    tgt   = (BOUNCE_CYC != 16'd0) ? BOUNCE_OUT : GAP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            GAP: begin
                if (cnt_q <= 16'd1) begin
                    enter = 1'b1;
                    tgt   = IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                enter = 1'b1;
                tgt   = IDLE;
            end
        endcase

        // Phase entry: load the phase length and the contact value of its first cycle.
        if (enter) begin
            state_d = tgt;
            case (tgt)
                BOUNCE_IN, BOUNCE_OUT: begin
                    cnt_d     = BOUNCE_CYC;
                    contact_d = lfsr_q[0];
                    lfsr_d    = lfsr_nx;
                end
                HOLD: begin
                    cnt_d     = hold_eff;
                    contact_d = 1'b1;
                end
                GAP: begin
                    cnt_d     = gap_eff;
                    contact_d = 1'b0;
                    if (state_q != IDLE) pcnt_d = pcnt_q + 8'd1;
                end
                default: begin
                    cnt_d     = 16'd0;
                    contact_d = 1'b0;
                end
            endcase
        end

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);

        for (int c = 0; c < 3; c++) begin
            columnas_d[c] = contact_q && (col_q == 2'(c)) && filas[row_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            lfsr_q     <= LFSR_SEED;
            hold_q     <= 16'd0;
            row_q      <= 2'd0;
            col_q      <= 2'd0;
            contact_q  <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            pcnt_q     <= 8'd0;
            columnas_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
            hold_q     <= hold_d;
            row_q      <= row_d;
            col_q      <= col_d;
            contact_q  <= contact_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            pcnt_q     <= pcnt_d;
            columnas_q <= columnas_d;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign columnas      = columnas_q;
    assign busy          = busy_q;
    assign contact       = contact_q;
    assign cmd_err       = err_q;
    assign press_cnt     = pcnt_q;
    assign state_dbg     = state_q;
endmodule
